// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network inference and learning blocks.
// Holds the learning FSM state type, the ternary reward encodings and the nibble saturator.
package snn_pkg;

  typedef enum logic [2:0] {
    RW_IDLE,
    RW_EVAL,
    RW_RD_REQ,
    RW_RD_WAIT,
    RW_MOD,
    RW_WR_REQ,
    RW_DONE
  } rw_state_t;

  localparam logic [1:0] RW_POS  = 2'b01;
  localparam logic [1:0] RW_ZERO = 2'b00;
  localparam logic [1:0] RW_NEG  = 2'b11;

  // Signed 4-bit weight plus signed 2-bit step, clamped to [-8, 7].
  function automatic logic [3:0] sat_add_s4(input logic [3:0] a, input logic [1:0] d);
    logic signed [4:0] sum;
    sum = $signed({a[3], a}) + $signed({{3{d[1]}}, d});
    if (sum > 5'sd7)
      return 4'h7;
    else if (sum < -5'sd8)
      return 4'h8;
    else
      return sum[3:0];
  endfunction

endpackage

// File: rtl/nibble_sat_update.sv
// Nudges both packed signed 4-bit weights of one memory word by the reward,
// saturating each nibble independently.
module nibble_sat_update
  import snn_pkg::*;
(
  input  logic [7:0] word,
  input  logic [1:0] delta,
  output logic [7:0] result
);

  assign result = {sat_add_s4(word[7:4], delta), sat_add_s4(word[3:0], delta)};

endmodule

// File: rtl/reward_update.sv
// Reward-driven weight update: compares prediction with target, then walks the
// weight words with read-modify-write, nudging every nibble by the ternary reward.
module reward_update
  import snn_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DW      = 8,
  parameter int N_WORDS = 2,
  parameter int TOL     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [7:0]        prediction,
  input  logic [7:0]        target,
  input  logic              learn_en,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DW-1:0]     rd_data,
  output logic              wb_req,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DW-1:0]     wb_wdata,
  input  logic              wb_ack,
  output logic              busy,
  output logic [1:0]        reward,
  output logic              upd_done,
  output logic [7:0]        hit_cnt
);

  rw_state_t         state, state_next;
  logic [7:0]        pred_q, target_q;
  logic [DW-1:0]     rdata_q, wdata_q, mod_word;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        reward_q;
  logic [7:0]        hit_q;
  logic signed [8:0] diff;
  logic [8:0]        diff_abs;
  logic              within_tol, last_word, accept;

  assign accept     = pred_valid && learn_en;
  assign diff       = $signed({1'b0, target_q}) - $signed({1'b0, pred_q});
  assign diff_abs   = diff[8] ? -diff : diff;
  assign within_tol = (32'(diff_abs) <= 32'(TOL));
  assign last_word  = (idx == ADDR_W'(N_WORDS - 1));

  nibble_sat_update u_nibble (
    .word   (rdata_q),
    .delta  (reward_q),
    .result (mod_word)
  );

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= RW_IDLE;
    else     state <= state_next;
  end

  // NOTE: default assigned first so no branch leaves state_next unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      RW_IDLE:    if (accept) state_next = RW_EVAL;
      RW_EVAL:    state_next = within_tol ? RW_DONE : RW_RD_REQ;
      RW_RD_REQ:  state_next = RW_RD_WAIT;
      RW_RD_WAIT: if (rd_valid) state_next = RW_MOD;
      RW_MOD:     state_next = RW_WR_REQ;
      RW_WR_REQ:  if (wb_ack) state_next = last_word ? RW_DONE : RW_RD_REQ;
      RW_DONE:    state_next = RW_IDLE;
      default:    state_next = RW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_q   <= '0;
      target_q <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      idx      <= '0;
      reward_q <= RW_ZERO;
      hit_q    <= '0;
    end else begin
      case (state)
        RW_IDLE: begin
          if (accept) begin
            pred_q   <= prediction;
            target_q <= target;
          end
        end
        RW_EVAL: begin
          if (within_tol) begin
            reward_q <= RW_ZERO;
            if (hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
          end else begin
            reward_q <= (target_q > pred_q) ? RW_POS : RW_NEG;
            idx      <= '0;
          end
        end
        RW_RD_WAIT: if (rd_valid) rdata_q <= rd_data;
        RW_MOD:     wdata_q <= mod_word;
        RW_WR_REQ:  if (wb_ack && !last_word) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Bus outputs are forced to zero whenever their request is idle.
  assign rd_req   = (state == RW_RD_REQ);
  assign rd_addr  = rd_req ? idx : '0;
  assign wb_req   = (state == RW_WR_REQ);
  assign wb_addr  = wb_req ? idx : '0;
  assign wb_wdata = wb_req ? wdata_q : '0;
  assign busy     = (state != RW_IDLE);
  assign upd_done = (state == RW_DONE);
  assign reward   = reward_q;
  assign hit_cnt  = hit_q;

endmodule
